// File: rtl/pcap_mem_writer.sv
// pcap_mem_writer: packs an AXI4-Stream packet flow into replay-memory words
// (one header word, then data words) and streams them out over a valid/ready write port.
module pcap_mem_writer #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int QDR_ADDR_WIDTH       = 19,
  parameter int PKT_COUNT_WIDTH      = 32,
  parameter int MEM_WORD_WIDTH       = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8 + 2
) (
  input  logic                              axi_aclk,
  input  logic                              axi_rst,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  output logic                              mem_wr_valid,
  input  logic                              mem_wr_ready,
  output logic [QDR_ADDR_WIDTH-1:0]         mem_wr_addr,
  output logic [MEM_WORD_WIDTH-1:0]         mem_wr_data,
  input  logic                              start_capture,
  input  logic [QDR_ADDR_WIDTH-1:0]         mem_addr_high,
  input  logic [PKT_COUNT_WIDTH-1:0]        capture_count,
  output logic                              capture_busy,
  output logic                              capture_done,
  output logic [QDR_ADDR_WIDTH-1:0]         mem_addr_last,
  output logic [PKT_COUNT_WIDTH-1:0]        pkt_stored,
  output logic                              truncated
);

  localparam int STRB_W = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [QDR_ADDR_WIDTH-1:0]  ADDR_ONE = QDR_ADDR_WIDTH'(1);
  localparam logic [PKT_COUNT_WIDTH-1:0] PKT_ONE  = PKT_COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_HDR  = 3'd2,
    ST_DATA = 3'd3,
    ST_DROP = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t                       r_state, w_state_nxt;
  logic [QDR_ADDR_WIDTH-1:0]    r_addr, w_addr_nxt;
  logic [QDR_ADDR_WIDTH-1:0]    r_addr_last, w_addr_last_nxt;
  logic [PKT_COUNT_WIDTH-1:0]   r_pkt, w_pkt_nxt;
  logic                         r_done, w_done_nxt;
  logic                         r_trunc, w_trunc_nxt;
  logic                         r_in_pkt, w_in_pkt_nxt;
  logic                         r_start_d;

  logic                         w_rise, w_fall;
  logic                         w_tready, w_beat_acc, w_wr_valid, w_wr_fire;
  logic                         w_limit_hit, w_no_room, w_at_high, w_hdr_go;
  logic [C_S_AXIS_DATA_WIDTH-1:0] w_user_ext;
  logic [MEM_WORD_WIDTH-1:0]    w_wr_data;

  assign w_rise       = start_capture & ~r_start_d;
  assign w_fall       = ~start_capture & r_start_d;
  assign w_limit_hit  = (capture_count != '0) && (r_pkt == capture_count);
  // addr+1 > high rewritten without the +1 so it cannot wrap at the top of memory
  assign w_no_room    = (r_addr >= mem_addr_high);
  assign w_at_high    = (r_addr == mem_addr_high);
  assign w_hdr_go     = (r_state == ST_HDR) & start_capture & ~w_limit_hit & ~w_no_room;

  assign w_tready     = (r_state == ST_HDR)  ? 1'b0 :
                        (r_state == ST_DATA) ? mem_wr_ready : 1'b1;
  assign w_beat_acc   = s_axis_tvalid & w_tready;
  assign w_in_pkt_nxt = w_beat_acc ? ~s_axis_tlast : r_in_pkt;

  assign w_wr_valid   = s_axis_tvalid & (w_hdr_go | (r_state == ST_DATA));
  assign w_wr_fire    = w_wr_valid & mem_wr_ready;
  assign w_user_ext   = C_S_AXIS_DATA_WIDTH'(s_axis_tuser);
  assign w_wr_data    = (r_state == ST_DATA) ?
                        {1'b0, s_axis_tlast | w_at_high, s_axis_tstrb, s_axis_tdata} :
                        {1'b1, 1'b0, {STRB_W{1'b0}}, w_user_ext};

  assign s_axis_tready = w_tready;
  assign mem_wr_valid  = w_wr_valid;
  assign mem_wr_addr   = r_addr;
  assign mem_wr_data   = w_wr_data;
  assign capture_busy  = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign capture_done  = r_done;
  assign mem_addr_last = r_addr_last;
  assign pkt_stored    = r_pkt;
  assign truncated     = r_trunc;

  // Capture sequencing: next state plus address/counter/flag updates.
  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr;
    w_addr_last_nxt = r_addr_last;
    w_pkt_nxt       = r_pkt;
    w_done_nxt      = r_done;
    w_trunc_nxt     = r_trunc;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (w_rise) begin
          w_addr_nxt  = '0;
          w_pkt_nxt   = '0;
          w_done_nxt  = 1'b0;
          w_trunc_nxt = 1'b0;
          // joining mid-packet would store a headless fragment, so resync first
          w_state_nxt = w_in_pkt_nxt ? ST_SYNC : ST_HDR;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_SYNC: begin
        if (w_fall) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end else if (w_beat_acc && s_axis_tlast) begin
          w_state_nxt = ST_HDR;
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_HDR: begin
        if (!start_capture || w_limit_hit || w_no_room) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else if (w_wr_fire) begin
          w_addr_nxt  = r_addr + ADDR_ONE;
          w_state_nxt = ST_DATA;
        end else begin
          w_state_nxt = ST_HDR;
        end
      end
      ST_DATA: begin
        if (w_wr_fire) begin
          w_addr_last_nxt = r_addr;
          if (s_axis_tlast) begin
            w_pkt_nxt   = r_pkt + PKT_ONE;
            w_addr_nxt  = w_at_high ? r_addr : r_addr + ADDR_ONE;
            w_state_nxt = ST_HDR;
          end else if (w_at_high) begin
            w_pkt_nxt   = r_pkt + PKT_ONE;
            w_trunc_nxt = 1'b1;
            w_state_nxt = ST_DROP;
          end else begin
            w_addr_nxt  = r_addr + ADDR_ONE;
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DROP: begin
        if (w_beat_acc && s_axis_tlast) begin
          w_state_nxt = ST_DONE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and bookkeeping registers.
  always_ff @(posedge axi_aclk) begin
    if (axi_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_addr_last <= '0;
      r_pkt       <= '0;
      r_done      <= 1'b0;
      r_trunc     <= 1'b0;
      r_in_pkt    <= 1'b0;
      r_start_d   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr      <= w_addr_nxt;
      r_addr_last <= w_addr_last_nxt;
      r_pkt       <= w_pkt_nxt;
      r_done      <= w_done_nxt;
      r_trunc     <= w_trunc_nxt;
      r_in_pkt    <= w_in_pkt_nxt;
      r_start_d   <= start_capture;
    end
  end

endmodule

// File: tb/tb_pcap_mem_writer.sv
// Randomized bench for pcap_mem_writer: expected memory images come from a
// packet-level model of the capture rules and are compared against observed writes.
module tb_pcap_mem_writer;

  localparam int DW = 256;
  localparam int UW = 128;
  localparam int AW = 19;
  localparam int CW = 32;
  localparam int SW = DW / 8;
  localparam int MW = DW + SW + 2;

  logic          axi_aclk = 1'b0;
  logic          axi_rst;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [MW-1:0] mem_wr_data;
  logic          start_capture;
  logic [AW-1:0] mem_addr_high;
  logic [CW-1:0] capture_count;
  logic          capture_busy;
  logic          capture_done;
  logic [AW-1:0] mem_addr_last;
  logic [CW-1:0] pkt_stored;
  logic          truncated;

  always #5 axi_aclk = ~axi_aclk;

  pcap_mem_writer dut (
    .axi_aclk(axi_aclk), .axi_rst(axi_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .start_capture(start_capture), .mem_addr_high(mem_addr_high),
    .capture_count(capture_count), .capture_busy(capture_busy), .capture_done(capture_done),
    .mem_addr_last(mem_addr_last), .pkt_stored(pkt_stored), .truncated(truncated)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [MW-1:0] word;
  } wr_t;

  beat_t pkt_q[$];
  wr_t   exp_q[$];
  wr_t   act_q[$];

  int          checks = 0;
  int          failures = 0;
  int          exp_stored;
  logic        exp_trunc;
  logic        exp_busy;
  logic [AW-1:0] exp_last = '0;
  logic        rdy_rand = 1'b0;
  logic        mon_data = 1'b0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_wide();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic step();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic add_pkt(input int len, input logic [UW-1:0] user);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd_wide();
      b.strb = $urandom;
      b.user = (i == 0) ? user : UW'(rnd_wide());
      b.last = (i == len - 1);
      pkt_q.push_back(b);
    end
  endtask

  // Packet-level capture rules: header then data words, stop on limit,
  // lack of room for header+1 data word, or truncation at the high address.
  task automatic model(input int high, input int cnt);
    int  addr;
    int  i;
    bit  stop;
    bit  pkt_end;
    logic l;
    addr = 0; i = 0; stop = 0;
    exp_q.delete();
    exp_stored = 0;
    exp_trunc = 1'b0;
    while (!stop) begin
      if ((cnt != 0 && exp_stored == cnt) || (addr + 1 > high)) begin
        stop = 1;
      end else if (i >= pkt_q.size()) begin
        break;
      end else begin
        exp_q.push_back('{addr: AW'(addr), word: {1'b1, 1'b0, {SW{1'b0}}, DW'(pkt_q[i].user)}});
        addr++;
        pkt_end = 0;
        while (!pkt_end) begin
          l = pkt_q[i].last || (addr == high);
          exp_q.push_back('{addr: AW'(addr), word: {1'b0, l, pkt_q[i].strb, pkt_q[i].data}});
          exp_last = AW'(addr);
          if (pkt_q[i].last) begin
            exp_stored++;
            pkt_end = 1;
          end else if (addr == high) begin
            exp_stored++;
            exp_trunc = 1'b1;
            pkt_end = 1;
            stop = 1;
          end
          addr++;
          i++;
        end
      end
    end
    exp_busy = !stop;
  endtask

  task automatic send_beat(input beat_t b);
    int   n;
    logic acc;
    s_axis_tdata  = b.data;
    s_axis_tstrb  = b.strb;
    s_axis_tuser  = b.user;
    s_axis_tlast  = b.last;
    s_axis_tvalid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 500) begin
      @(negedge axi_aclk);
      acc = s_axis_tready;
      step();
      n++;
    end
    s_axis_tvalid = 1'b0;
    check("beat_accept", acc, 1'b1);
  endtask

  task automatic send_pkts();
    foreach (pkt_q[k]) begin
      send_beat(pkt_q[k]);
      idle($urandom_range(0, 2));
    end
  endtask

  task automatic setup(input int high, input int cnt, input logic rr);
    mem_addr_high = AW'(high);
    capture_count = CW'(cnt);
    rdy_rand = rr;
    model(high, cnt);
    act_q.delete();
  endtask

  task automatic finish_capture(input string tag);
    idle(4);
    @(negedge axi_aclk);
    check({tag, "_busy_armed"}, capture_busy, exp_busy);
    step();
    start_capture = 1'b0;
    idle(3);
    @(negedge axi_aclk);
    check({tag, "_nwr"}, act_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < act_q.size()) begin
        check({tag, "_addr"}, act_q[k].addr, exp_q[k].addr);
        check({tag, "_word"}, act_q[k].word, exp_q[k].word);
      end
    end
    check({tag, "_stored"}, pkt_stored, exp_stored);
    check({tag, "_trunc"}, truncated, exp_trunc);
    check({tag, "_last"}, mem_addr_last, exp_last);
    check({tag, "_done"}, capture_done, 1'b1);
    check({tag, "_busy_end"}, capture_busy, 1'b0);
    step();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, capture_busy, 1'b0);
    check({tag, "_done"}, capture_done, 1'b0);
    check({tag, "_trunc"}, truncated, 1'b0);
    check({tag, "_stored"}, pkt_stored, 0);
    check({tag, "_last"}, mem_addr_last, 0);
    check({tag, "_wvalid"}, mem_wr_valid, 1'b0);
    check({tag, "_tready"}, s_axis_tready, 1'b1);
  endtask

  initial begin
    mem_wr_ready = 1'b1;
    forever begin
      @(posedge axi_aclk);
      #1;
      mem_wr_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Write monitor; while a packet body is being written tready must follow mem_wr_ready.
  always @(negedge axi_aclk) begin
    if (axi_rst) begin
      mon_data <= 1'b0;
    end else begin
      if (mon_data) check("tready_mirror", s_axis_tready, mem_wr_ready);
      if (mem_wr_valid && mem_wr_ready) begin
        act_q.push_back('{addr: mem_wr_addr, word: mem_wr_data});
        if (mem_wr_data[MW-1]) mon_data <= 1'b1;
        else if (mem_wr_data[MW-2]) mon_data <= 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    beat_t pre [3];
    axi_rst = 1'b1;
    s_axis_tdata = '0; s_axis_tstrb = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    start_capture = 1'b0; mem_addr_high = '0; capture_count = '0;
    idle(3);
    @(negedge axi_aclk);
    check_reset("rst");
    step();
    axi_rst = 1'b0;
    idle(2);

    // three packets of 2, 1, 4 beats into plenty of room
    pkt_q.delete();
    add_pkt(2, UW'(8'hA1)); add_pkt(1, UW'(8'hA2)); add_pkt(4, UW'(8'hA3));
    setup(100, 0, 1'b0);
    start_capture = 1'b1; step();
    send_pkts();
    finish_capture("t1");

    // packet limit of 2 out of 4 offered
    pkt_q.delete();
    for (int p = 0; p < 4; p++) add_pkt(1, UW'(rnd_wide()));
    setup(100, 2, 1'b1);
    start_capture = 1'b1; step();
    send_pkts();
    finish_capture("t2");

    // truncation of an 8-beat packet at high address 5
    pkt_q.delete();
    add_pkt(8, UW'(rnd_wide()));
    setup(5, 0, 1'b0);
    start_capture = 1'b1; step();
    send_pkts();
    finish_capture("t3");

    // arm on the cycle beat 2 of a 3-beat packet is accepted
    for (int i = 0; i < 3; i++) begin
      pre[i].data = rnd_wide(); pre[i].strb = $urandom;
      pre[i].user = UW'(rnd_wide()); pre[i].last = (i == 2);
    end
    pkt_q.delete();
    add_pkt(2, UW'(rnd_wide()));
    setup(100, 0, 1'b0);
    send_beat(pre[0]);
    start_capture = 1'b1;
    send_beat(pre[1]);
    send_beat(pre[2]);
    check("t4_no_wr_sync", act_q.size(), 0);
    send_pkts();
    finish_capture("t4");

    // 6-beat packet with a randomly stalling controller
    pkt_q.delete();
    add_pkt(6, UW'(rnd_wide()));
    setup(100, 0, 1'b1);
    start_capture = 1'b1; step();
    send_pkts();
    finish_capture("t5");

    // reset during the third data beat, then a clean re-arm
    pkt_q.delete();
    add_pkt(6, UW'(rnd_wide()));
    mem_addr_high = AW'(100); capture_count = '0; rdy_rand = 1'b0;
    start_capture = 1'b1; step();
    send_beat(pkt_q[0]);
    send_beat(pkt_q[1]);
    s_axis_tdata = pkt_q[2].data; s_axis_tstrb = pkt_q[2].strb;
    s_axis_tuser = pkt_q[2].user; s_axis_tlast = pkt_q[2].last;
    s_axis_tvalid = 1'b1;
    axi_rst = 1'b1;
    step();
    @(negedge axi_aclk);
    check_reset("t6_rst");
    step();
    s_axis_tvalid = 1'b0;
    start_capture = 1'b0;
    axi_rst = 1'b0;
    exp_last = '0;
    idle(2);
    pkt_q.delete();
    add_pkt(3, UW'(rnd_wide()));
    setup(100, 0, 1'b1);
    start_capture = 1'b1; step();
    send_pkts();
    finish_capture("t6");

    // randomized limits, room and packet mixes
    for (int r = 0; r < 10; r++) begin
      int high;
      int cnt;
      int np;
      high = (r == 0) ? 0 : $urandom_range(2, 24);
      cnt  = $urandom_range(0, 3);
      np   = $urandom_range(1, 4);
      pkt_q.delete();
      for (int p = 0; p < np; p++) add_pkt($urandom_range(1, 6), UW'(rnd_wide()));
      setup(high, cnt, 1'b1);
      start_capture = 1'b1; step();
      send_pkts();
      finish_capture("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
